mont_final: RTL and testbench

- Bit-serial radix-2 Montgomery modular multiplier: M = A·B·R⁻¹ mod P, with R = 2^N (N = 256).
- Building block for the field-arithmetic layer of the ECC point-arithmetic datapath.
- Start/done handshake; one multiplication in flight at a time.

---
 rtl/mont_final_if.sv | 15 +
 rtl/mont_final.sv | 121 ++++++++++++
 tb/tb_mont_final.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mont_final_if.sv
// Start/done handshake bundle for the Montgomery multiplier: operands in,
// fully reduced product and result-valid level out.
interface mont_final_if #(
  parameter int N = 256
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] P;
  logic [N-1:0] M;
  logic         done;

  modport master (output start, output A, output B, output P, input M, input done);
  modport slave  (input start, input A, input B, input P, output M, output done);
endinterface

// File: rtl/mont_final.sv
// Bit-serial radix-2 Montgomery multiplier: M = A*B*2^-N mod P, one
// multiplicand bit consumed per cycle, followed by one conditional subtraction.
module mont_final #(
  parameter int N = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  mont_final_if.slave  bus
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_r;
  logic [N-1:0]    a_r;
  logic [N-1:0]    b_r;
  logic [N-1:0]    p_r;
  logic [N+1:0]    s_r;
  logic [CW-1:0]   cnt_r;
  logic [N-1:0]    m_r;
  logic            done_r;

  logic [N+1:0]    add_s;
  logic [N+1:0]    odd_s;
  logic [N+1:0]    shift_s;
  logic [N+1:0]    red_s;

  // One Montgomery iteration and the final conditional subtraction.
  always_comb begin
    add_s   = {(N+2){1'b0}};
    odd_s   = {(N+2){1'b0}};
    shift_s = {(N+2){1'b0}};
    red_s   = {(N+2){1'b0}};
    if (a_r[0]) begin
      add_s = s_r + {2'b00, b_r};
    end else begin
      add_s = s_r;
    end
    // Adding the odd modulus makes the sum even so the shift divides exactly by 2.
    if (add_s[0]) begin
      odd_s = add_s + {2'b00, p_r};
    end else begin
      odd_s = add_s;
    end
    shift_s = {1'b0, odd_s[N+1:1]};
    if (s_r >= {2'b00, p_r}) begin
      red_s = s_r - {2'b00, p_r};
    end else begin
      red_s = s_r;
    end
  end

  // Control FSM with registered result and done level.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r <= IDLE;
      a_r     <= {N{1'b0}};
      b_r     <= {N{1'b0}};
      p_r     <= {N{1'b0}};
      s_r     <= {(N+2){1'b0}};
      cnt_r   <= {CW{1'b0}};
      m_r     <= {N{1'b0}};
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_r     <= bus.A;
            b_r     <= bus.B;
            p_r     <= bus.P;
            s_r     <= {(N+2){1'b0}};
            cnt_r   <= {CW{1'b0}};
            state_r <= CALC;
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          s_r   <= shift_s;
          // A is shifted down so bit 0 always holds the current multiplicand bit.
          a_r   <= {1'b0, a_r[N-1:1]};
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == CW'(N-1)) begin
            state_r <= FINAL;
          end else begin
            state_r <= CALC;
          end
        end
        FINAL: begin
          m_r     <= red_s[N-1:0];
          done_r  <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          if (bus.start) begin
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            done_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.M    = m_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_mont_final.sv
// Randomized scoreboard bench for mont_final: expected products from a
// modular-arithmetic model are queued by the driver and checked by a monitor.
`timescale 1ns/1ps
module tb_mont_final;

  localparam int N = 256;

  typedef struct {
    logic [N-1:0] m;
    logic [N-1:0] p;
  } exp_t;

  logic clk;
  logic rst_n;
  mont_final_if #(.N(N)) bus ();

  mont_final #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(10ns * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input bit ok, input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [N-1:0] rand256();
    logic [N-1:0] r;
    for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // A*B reduced mod P, then divided by two mod P N times (x/2 or (x+P)/2).
  function automatic logic [N-1:0] ref_mont(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] p);
    logic [2*N-1:0] prod;
    logic [N:0]     x;
    prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    prod = prod % {{N{1'b0}}, p};
    x = prod[N:0];
    for (int i = 0; i < N; i++) begin
      if (x[0]) x = x + {1'b0, p};
      x = x >> 1;
    end
    return x[N-1:0];
  endfunction

  // Monitor: every rising done pops one expectation.
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1 && done_prev !== 1'b1) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_done", bus.M, {N{1'b0}});
        end else begin
          e = exp_q.pop_front();
          chk(bus.M === e.m, "result", bus.M, e.m);
          chk(bus.M < e.p, "reduced", bus.M, e.p);
        end
      end
      done_prev = bus.done;
    end
  end

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] p,
                        input logic [N-1:0] expm, input int hold, input bit scramble);
    int edges;
    bit got;
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.P = p;
    bus.start = 1'b1;
    exp_q.push_back('{m: expm, p: p});
    edges = 0;
    got = 1'b0;
    while (edges < 400 && !got) begin
      @(posedge clk);
      #1;
      edges++;
      if (scramble && edges == 2) begin
        bus.A = rand256();
        bus.B = rand256();
        bus.P = rand256();
      end
      if (bus.done === 1'b1) got = 1'b1;
    end
    chk(got && edges == 258, "latency", N'(edges), N'(258));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      chk(bus.done === 1'b1, "done_hold", N'(bus.done), N'(1));
      chk(bus.M === expm, "m_hold", bus.M, expm);
    end
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk(bus.done === 1'b0, "done_fall", N'(bus.done), N'(0));
    chk(bus.M === expm, "m_keep", bus.M, expm);
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] p, a, b, big;
    bus.start = 1'b0;
    bus.A = {N{1'b0}};
    bus.B = {N{1'b0}};
    bus.P = {N{1'b0}};
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk(bus.M === {N{1'b0}}, "reset_m", bus.M, {N{1'b0}});
    chk(bus.done === 1'b0, "reset_done", N'(bus.done), N'(0));
    @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk(bus.done === 1'b0, "idle_done", N'(bus.done), N'(0));

    p = N'(101);
    run_op(N'(3),  N'(5),  p, N'(55), 20, 1'b1);
    run_op(N'(7),  N'(11), p, N'(13), 0, 1'b0);
    run_op(N'(13), N'(17), p, N'(36), 0, 1'b1);
    run_op(N'(19), N'(23), p, N'(20), 0, 1'b0);
    run_op(N'(29), N'(31), p, N'(98), 0, 1'b0);
    run_op(N'(37), N'(42), p, N'(42), 0, 1'b0);
    run_op(N'(0),  N'(50), p, N'(0),  0, 1'b0);
    run_op(N'(64), N'(0),  p, N'(0),  0, 1'b1);

    big = N'(1) << 255;
    big = big - N'(19);
    run_op(big - N'(1), big - N'(1), big, ref_mont(big - N'(1), big - N'(1), big), 0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      p = rand256();
      p[N-1] = 1'b1;
      p[0] = 1'b1;
      a = rand256() % p;
      b = rand256() % p;
      run_op(a, b, p, ref_mont(a, b, p), 0, t[0]);
    end

    // Abort a run at iteration 100 and confirm nothing leaks into the next one.
    @(negedge clk);
    bus.A = rand256();
    bus.B = rand256();
    bus.P = big;
    bus.start = 1'b1;
    repeat (101) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk(bus.M === {N{1'b0}}, "midreset_m", bus.M, {N{1'b0}});
    chk(bus.done === 1'b0, "midreset_done", N'(bus.done), N'(0));
    @(negedge clk);
    rst_n = 1'b0;
    run_op(N'(29), N'(31), N'(101), N'(98), 0, 1'b0);
    a = rand256() % big;
    b = rand256() % big;
    run_op(a, b, big, ref_mont(a, b, big), 0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk(exp_q.size() == 0, "queue_drained", N'(exp_q.size()), N'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
